// File: rtl/output_unit_pkg.sv
// Shared widths, message layouts and FSM encoding for the BFU packet-output stage.
package output_unit_pkg;

    localparam int unsigned DATA_W    = 512;
    localparam int unsigned REG_W     = 192;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned OFS_W     = 6;
    localparam int unsigned EMPTY_W   = 6;
    localparam int unsigned CMD_W     = 36;
    localparam int unsigned RDREQ_W   = 14;
    localparam int unsigned RDRSP_W   = 2 * REG_W;
    localparam int unsigned STREAM_W  = DATA_W + EMPTY_W + 1 + TAG_W;
    localparam int unsigned BFU_OUT_W = CMD_W + 1;

    typedef struct packed {
        logic [21:0]      rsvd;
        logic [4:0]       reg_b;
        logic [4:0]       reg_a;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } stream_msg_t;

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StOut} state_e;

endpackage

// File: rtl/output_unit_placer.sv
// Places two registers at independent byte offsets in one output beat; overlaps are OR-ed,
// bytes shifted past the top of the beat are dropped.
module output_unit_placer
    import output_unit_pkg::*;
(
    input  logic [REG_W-1:0]  reg_a_i,
    input  logic [REG_W-1:0]  reg_b_i,
    input  logic [OFS_W-1:0]  ofs_a_i,
    input  logic [OFS_W-1:0]  ofs_b_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] a_ext;
    logic [DATA_W-1:0] b_ext;

    assign a_ext = {{(DATA_W - REG_W){1'b0}}, reg_a_i};
    assign b_ext = {{(DATA_W - REG_W){1'b0}}, reg_b_i};

    assign data_o = (a_ext << {ofs_a_i, 3'b000}) | (b_ext << {ofs_b_i, 3'b000});

endmodule

// File: rtl/output_unit.sv
// BFU packet-output stage: read two registers, place them in one beat, emit beat and completion.
module output_unit
    import output_unit_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          bt0,
    input  logic [31:0]          bt1,
    input  logic                 cmd_in_t_val,
    output logic                 cmd_in_t_rdy,
    input  logic [CMD_W-1:0]     cmd_in_t_msg,
    output logic                 bfu_rdreq_t_val,
    input  logic                 bfu_rdreq_t_rdy,
    output logic [RDREQ_W-1:0]   bfu_rdreq_t_msg,
    input  logic                 bfu_rdrsp_t_val,
    output logic                 bfu_rdrsp_t_rdy,
    input  logic [RDRSP_W-1:0]   bfu_rdrsp_t_msg,
    output logic                 stream_out_t_val,
    input  logic                 stream_out_t_rdy,
    output logic [STREAM_W-1:0]  stream_out_t_msg,
    output logic                 bfu_out_t_val,
    input  logic                 bfu_out_t_rdy,
    output logic [BFU_OUT_W-1:0] bfu_out_t_msg
);

    state_e               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    stream_msg_t          stream_msg_q, stream_msg_d;
    logic [BFU_OUT_W-1:0] bfu_msg_q, bfu_msg_d;
    logic                 cmd_rdy_q, cmd_rdy_d;
    logic                 rdreq_val_q, rdreq_val_d;
    logic                 rsp_rdy_q, rsp_rdy_d;
    logic                 stream_val_q, stream_val_d;
    logic                 bfu_val_q, bfu_val_d;
    logic [DATA_W-1:0]    placed_data;
    logic                 unused_bt;

    assign unused_bt = ^{bt0[31:OFS_W], bt1[31:OFS_W]};

    output_unit_placer u_placer (
        .reg_a_i (bfu_rdrsp_t_msg[REG_W-1:0]),
        .reg_b_i (bfu_rdrsp_t_msg[RDRSP_W-1:REG_W]),
        .ofs_a_i (bt0[OFS_W-1:0]),
        .ofs_b_i (bt1[OFS_W-1:0]),
        .data_o  (placed_data)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        stream_msg_d = stream_msg_q;
        bfu_msg_d    = bfu_msg_q;
        cmd_rdy_d    = 1'b0;
        rdreq_val_d  = rdreq_val_q;
        rsp_rdy_d    = 1'b0;
        stream_val_d = stream_val_q;
        bfu_val_d    = bfu_val_q;
        unique case (state_q)
            StIdle: begin
                cmd_rdy_d = 1'b1;
                if (cmd_in_t_val && cmd_rdy_q) begin
                    cmd_d       = cmd_t'(cmd_in_t_msg);
                    cmd_rdy_d   = 1'b0;
                    rdreq_val_d = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (rdreq_val_q && bfu_rdreq_t_rdy) begin
                    rdreq_val_d = 1'b0;
                    rsp_rdy_d   = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                rsp_rdy_d = 1'b1;
                if (rsp_rdy_q && bfu_rdrsp_t_val) begin
                    rsp_rdy_d          = 1'b0;
                    stream_msg_d.data  = placed_data;
                    stream_msg_d.empty = '0;
                    stream_msg_d.eop   = 1'b1;
                    stream_msg_d.tag   = cmd_q.tag;
                    bfu_msg_d          = {1'b1, cmd_q};
                    stream_val_d       = 1'b1;
                    bfu_val_d          = 1'b1;
                    state_d            = StOut;
                end
            end
            StOut: begin
                // Both output channels retire independently; leave only when both are done.
                stream_val_d = stream_val_q & ~stream_out_t_rdy;
                bfu_val_d    = bfu_val_q & ~bfu_out_t_rdy;
                if (!stream_val_d && !bfu_val_d) begin
                    cmd_rdy_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            stream_msg_q <= '0;
            bfu_msg_q    <= '0;
            cmd_rdy_q    <= 1'b0;
            rdreq_val_q  <= 1'b0;
            rsp_rdy_q    <= 1'b0;
            stream_val_q <= 1'b0;
            bfu_val_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            stream_msg_q <= stream_msg_d;
            bfu_msg_q    <= bfu_msg_d;
            cmd_rdy_q    <= cmd_rdy_d;
            rdreq_val_q  <= rdreq_val_d;
            rsp_rdy_q    <= rsp_rdy_d;
            stream_val_q <= stream_val_d;
            bfu_val_q    <= bfu_val_d;
        end
    end

    assign cmd_in_t_rdy     = cmd_rdy_q;
    assign bfu_rdreq_t_val  = rdreq_val_q;
    assign bfu_rdreq_t_msg  = cmd_q[RDREQ_W-1:0];
    assign bfu_rdrsp_t_rdy  = rsp_rdy_q;
    assign stream_out_t_val = stream_val_q;
    assign stream_out_t_msg = stream_msg_q;
    assign bfu_out_t_val    = bfu_val_q;
    assign bfu_out_t_msg    = bfu_msg_q;

endmodule

// File: tb/tb_output_unit.sv
// Directed plus randomized bench for output_unit against a byte-level placement model.
module tb_output_unit;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [31:0]  bt0, bt1;
    logic         cmd_in_t_val, cmd_in_t_rdy;
    logic [35:0]  cmd_in_t_msg;
    logic         bfu_rdreq_t_val, bfu_rdreq_t_rdy;
    logic [13:0]  bfu_rdreq_t_msg;
    logic         bfu_rdrsp_t_val, bfu_rdrsp_t_rdy;
    logic [383:0] bfu_rdrsp_t_msg;
    logic         stream_out_t_val, stream_out_t_rdy;
    logic [522:0] stream_out_t_msg;
    logic         bfu_out_t_val, bfu_out_t_rdy;
    logic [36:0]  bfu_out_t_msg;

    int vectors = 0;
    int miscompares = 0;
    logic [191:0] regfile [32];

    always #5 i_clk = ~i_clk;

    output_unit dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .bt0              (bt0),
        .bt1              (bt1),
        .cmd_in_t_val     (cmd_in_t_val),
        .cmd_in_t_rdy     (cmd_in_t_rdy),
        .cmd_in_t_msg     (cmd_in_t_msg),
        .bfu_rdreq_t_val  (bfu_rdreq_t_val),
        .bfu_rdreq_t_rdy  (bfu_rdreq_t_rdy),
        .bfu_rdreq_t_msg  (bfu_rdreq_t_msg),
        .bfu_rdrsp_t_val  (bfu_rdrsp_t_val),
        .bfu_rdrsp_t_rdy  (bfu_rdrsp_t_rdy),
        .bfu_rdrsp_t_msg  (bfu_rdrsp_t_msg),
        .stream_out_t_val (stream_out_t_val),
        .stream_out_t_rdy (stream_out_t_rdy),
        .stream_out_t_msg (stream_out_t_msg),
        .bfu_out_t_val    (bfu_out_t_val),
        .bfu_out_t_rdy    (bfu_out_t_rdy),
        .bfu_out_t_msg    (bfu_out_t_msg)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", name, obs, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [522:0] obs, input logic [522:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [191:0] rand192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Byte-by-byte placement: each source byte lands at offset+i unless that is past byte 63.
    function automatic logic [511:0] place(input logic [191:0] a, input logic [191:0] b,
                                           input int o0, input int o1);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 24; i++) begin
            if (o0 + i < 64) d[8*(o0+i) +: 8] = d[8*(o0+i) +: 8] | a[8*i +: 8];
            if (o1 + i < 64) d[8*(o1+i) +: 8] = d[8*(o1+i) +: 8] | b[8*i +: 8];
        end
        return d;
    endfunction

    task automatic run_cmd(input logic [21:0] hi, input logic [3:0] tag, input logic [4:0] ra,
                           input logic [4:0] rb, input int o0, input int o1,
                           input int sst, input int bst, input int req_dly);
        logic [35:0]  cmd;
        logic [522:0] exp_s;
        logic [36:0]  exp_b;
        logic         fs, fb, s_done, b_done;
        int           n;
        cmd = {hi, rb, ra, tag};
        cmd_in_t_val = 1'b1;
        cmd_in_t_msg = cmd;
        n = 0;
        while (!cmd_in_t_rdy && n < 50) begin
            tick();
            n++;
        end
        chk1("cmd_rdy_idle", cmd_in_t_rdy, 1'b1);
        tick();
        cmd_in_t_val = 1'b0;
        cmd_in_t_msg = {$urandom(), 4'($urandom())};
        chk1("rdreq_val_rise", bfu_rdreq_t_val, 1'b1);
        chkw("rdreq_msg", 523'(bfu_rdreq_t_msg), 523'(cmd[13:0]));
        chk1("cmd_rdy_busy", cmd_in_t_rdy, 1'b0);
        for (int i = 0; i < req_dly; i++) begin
            tick();
            chk1("rdreq_val_hold", bfu_rdreq_t_val, 1'b1);
            chkw("rdreq_msg_hold", 523'(bfu_rdreq_t_msg), 523'(cmd[13:0]));
        end
        bfu_rdreq_t_rdy = 1'b1;
        tick();
        bfu_rdreq_t_rdy = 1'b0;
        chk1("rdreq_val_drop", bfu_rdreq_t_val, 1'b0);
        chk1("rsp_rdy", bfu_rdrsp_t_rdy, 1'b1);
        bfu_rdrsp_t_val = 1'b1;
        bfu_rdrsp_t_msg = {regfile[rb], regfile[ra]};
        bt0 = {26'($urandom()), 6'(o0)};
        bt1 = {26'($urandom()), 6'(o1)};
        tick();
        bfu_rdrsp_t_val = 1'b0;
        bfu_rdrsp_t_msg = {rand192(), rand192()};
        bt0 = $urandom();
        bt1 = $urandom();
        exp_s = {tag, 1'b1, 6'd0, place(regfile[ra], regfile[rb], o0, o1)};
        exp_b = {1'b1, cmd};
        chk1("rsp_rdy_drop", bfu_rdrsp_t_rdy, 1'b0);
        s_done = 1'b0;
        b_done = 1'b0;
        n = 0;
        while (!(s_done && b_done) && n < 100) begin
            stream_out_t_rdy = (n >= sst);
            bfu_out_t_rdy    = (n >= bst);
            chk1("stream_val", stream_out_t_val, !s_done);
            chk1("bfu_out_val", bfu_out_t_val, !b_done);
            if (!s_done) chkw("stream_msg", stream_out_t_msg, exp_s);
            if (!b_done) chkw("bfu_out_msg", 523'(bfu_out_t_msg), 523'(exp_b));
            chk1("cmd_rdy_out", cmd_in_t_rdy, 1'b0);
            fs = stream_out_t_val & stream_out_t_rdy;
            fb = bfu_out_t_val & bfu_out_t_rdy;
            tick();
            if (fs) s_done = 1'b1;
            if (fb) b_done = 1'b1;
            n++;
        end
        stream_out_t_rdy = 1'b0;
        bfu_out_t_rdy    = 1'b0;
        chk1("out_both_done", s_done && b_done, 1'b1);
        chk1("stream_val_end", stream_out_t_val, 1'b0);
        chk1("bfu_out_val_end", bfu_out_t_val, 1'b0);
        chk1("cmd_rdy_return", cmd_in_t_rdy, 1'b1);
    endtask

    initial begin
        i_rst            = 1'b0;
        bt0              = '0;
        bt1              = '0;
        cmd_in_t_val     = 1'b0;
        cmd_in_t_msg     = '0;
        bfu_rdreq_t_rdy  = 1'b0;
        bfu_rdrsp_t_val  = 1'b0;
        bfu_rdrsp_t_msg  = '0;
        stream_out_t_rdy = 1'b0;
        bfu_out_t_rdy    = 1'b0;
        for (int i = 0; i < 32; i++) regfile[i] = rand192();

        // Reset
        repeat (10) tick();
        chk1("rst_cmd_rdy", cmd_in_t_rdy, 1'b0);
        chk1("rst_rdreq_val", bfu_rdreq_t_val, 1'b0);
        chk1("rst_rsp_rdy", bfu_rdrsp_t_rdy, 1'b0);
        chk1("rst_stream_val", stream_out_t_val, 1'b0);
        chk1("rst_bfu_out_val", bfu_out_t_val, 1'b0);
        chkw("rst_stream_msg", stream_out_t_msg, 523'd0);
        chkw("rst_bfu_out_msg", 523'(bfu_out_t_msg), 523'd0);
        i_rst = 1'b1;
        tick();
        chk1("post_rst_cmd_rdy", cmd_in_t_rdy, 1'b1);

        // Single command 0x090
        regfile[9] = 192'h00040003000200010004000300020001;
        run_cmd(22'd0, 4'd0, 5'd9, 5'd0, 0, 32, 0, 0, 0);
        chkw("single_data_a", 523'(stream_out_t_msg[191:0]), 523'(regfile[9]));
        chkw("single_data_b", 523'(stream_out_t_msg[447:256]), 523'(regfile[0]));
        chkw("single_data_gap", 523'(stream_out_t_msg[255:192]), 523'd0);
        chkw("single_data_top", 523'(stream_out_t_msg[522:448]), 523'({4'd0, 1'b1, 6'd0, 64'd0}));
        chkw("single_bfu_msg", 523'(bfu_out_t_msg), 523'(37'h10_0000_0090));

        // Back-to-back 0x091
        run_cmd(22'd0, 4'd1, 5'd9, 5'd0, 0, 32, 0, 0, 0);
        chkw("b2b_tag", 523'(stream_out_t_msg[522:519]), 523'd1);

        // Stream backpressure, completion port free
        run_cmd(22'h2a5a5, 4'd5, 5'd3, 5'd17, 10, 20, 5, 0, 2);

        // Offset truncation
        regfile[31] = '1;
        regfile[30] = '0;
        run_cmd(22'd0, 4'd7, 5'd31, 5'd30, 48, 13, 0, 2, 0);
        chkw("trunc_hi_ones", 523'(stream_out_t_msg[511:384]), 523'({128{1'b1}}));
        chkw("trunc_lo_zero", 523'(stream_out_t_msg[383:0]), 523'd0);

        // Reset while a read response is pending
        cmd_in_t_val = 1'b1;
        cmd_in_t_msg = 36'h0000_0235;
        tick();
        cmd_in_t_val = 1'b0;
        bfu_rdreq_t_rdy = 1'b1;
        tick();
        bfu_rdreq_t_rdy = 1'b0;
        chk1("rstrsp_rsp_rdy", bfu_rdrsp_t_rdy, 1'b1);
        bfu_rdrsp_t_val = 1'b1;
        bfu_rdrsp_t_msg = {regfile[3], regfile[5]};
        #1;
        i_rst = 1'b0;
        #1;
        chk1("rstrsp_rdy_async", bfu_rdrsp_t_rdy, 1'b0);
        repeat (3) tick();
        i_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("rstrsp_no_ack", bfu_rdrsp_t_rdy, 1'b0);
            chk1("rstrsp_no_stream", stream_out_t_val, 1'b0);
            chk1("rstrsp_no_bfu_out", bfu_out_t_val, 1'b0);
        end
        bfu_rdrsp_t_val = 1'b0;
        run_cmd(22'd0, 4'd2, 5'd5, 5'd3, 40, 41, 1, 3, 1);

        // Randomized commands
        for (int k = 0; k < 25; k++) begin
            logic [4:0] ra, rb;
            ra = 5'($urandom());
            rb = 5'($urandom());
            regfile[ra] = rand192();
            regfile[rb] = rand192();
            run_cmd(22'($urandom()), 4'($urandom()), ra, rb,
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_unit.md
Name: output_unit

Overview:
- Packet-output stage of a BFU (block functional unit).
- Accepts a command naming two register-file entries and issues one read request.
- Places the two returned 192-bit registers at programmable byte offsets (bt0/bt1) in a single 512-bit output beat, emits that beat on the stream port, then posts a completion on the BFU output port.
- Processes one command at a time.

Parameters:
- DATA_W, 512, stream data beat width in bits.
- REG_W, 192, width of one register-file entry.
- TAG_W, 4, command tag width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- bt0  in  32  byte offset of register A in the output beat; bits [5:0] used
- bt1  in  32  byte offset of register B in the output beat; bits [5:0] used
- cmd_in_t_val/rdy/msg  in/out/in  1/1/36  command; [3:0] tag, [8:4] regA index, [13:9] regB index, [35:14] ignored
- bfu_rdreq_t_val/rdy/msg  out/in/out  1/1/14  read request; msg = cmd[13:0]
- bfu_rdrsp_t_val/rdy/msg  in/out/in  1/1/384  read response; [191:0] = regA, [383:192] = regB
- stream_out_t_val/rdy/msg  out/in/out  1/1/523  output beat; [511:0] data, [517:512] empty (always 0), [518] eop (always 1), [522:519] tag
- bfu_out_t_val/rdy/msg  out/in/out  1/1/37  completion; [35:0] = command echo, [36] = 1 (done)

Behaviour:
- All channels use val/rdy handshaking; a transfer occurs on a rising edge with val=1 and rdy=1.
- Once val is asserted it holds, with msg stable, until the transfer.
- FSM states and transitions:
  - IDLE: cmd_in_t_rdy=1. On cmd transfer, latch msg into cmd_r and go to REQ.
  - REQ: bfu_rdreq_t_val=1, msg=cmd_r[13:0]. On transfer go to RSP.
  - RSP: bfu_rdrsp_t_rdy=1. On transfer, build the output beat and go to OUT.
  - OUT: stream_out_t_val and bfu_out_t_val both rise in the same cycle. Each drops independently after its own transfer. When both have completed, return to IDLE.
- cmd_in_t_rdy=0 in every state other than IDLE. bfu_rdrsp_t_rdy=0 outside RSP.
- Output beat construction, with A=rsp[191:0] and B=rsp[383:192], and all other bytes zero:
  - data = (A << 8*bt0[5:0]) | (B << 8*bt1[5:0]), truncated to 512 bits; bytes pushed above byte 63 are dropped.
  - If the two placements overlap, the overlapping bytes are OR-ed.
  - bt0/bt1 are sampled in the RSP transfer cycle.
- All outputs are registered. Minimum latencies:
  - rdreq_val rises 1 cycle after cmd acceptance.
  - stream_out/bfu_out val rise 1 cycle after rdrsp acceptance.
- A second cmd is not accepted until both OUT handshakes finish. The earliest acceptance is in the cycle after the last OUT transfer.
- Reset (i_rst=0, asynchronous): state=IDLE; all val outputs=0; all rdy outputs=0; all msg registers=0. cmd_in_t_rdy rises in the first cycle after reset deassertion.
- Reset asserted mid-operation: the transaction is abandoned, no partial output is emitted, and any outstanding read response is not consumed.
- A rdrsp val arriving outside RSP is ignored; it is not acknowledged.

Decomposition:
- Shared package output_unit_pkg holds:
  - widths DATA_W, REG_W, TAG_W;
  - a struct for cmd fields (tag, reg_a, reg_b);
  - a struct for the stream msg (data, empty, eop, tag);
  - the FSM state enum.
- One natural sub-module: output_unit_placer, the combinational byte shifter/merger that takes A, B, bt0, bt1 and produces the 512-bit data.

Test Plan:
- Reset: hold i_rst=0 for 10 cycles -> every val and rdy output is 0. After release, cmd_in_t_rdy=1 within 1 cycle.
- Single command:
  - stimulus: bt0=0, bt1=32; cmd 0x090; responder returns regfile[9] and regfile[0], with regfile[9]=0x...00040003000200010004000300020001.
  - required: rdreq msg = 0x090.
  - required: stream data[191:0] = regfile[9], data[447:256] = regfile[0], all other bits 0; tag=0, eop=1, empty=0.
  - required: bfu_out msg = {1'b1, 36'h000000090}.
- Back-to-back: after the bfu_out_t_val of the 0x090 command, send cmd 0x091 -> accepted only after both OUT transfers. Output tag=1; rdreq msg = 0x091.
- Backpressure: stream_out_t_rdy=0 for 5 cycles while bfu_out_t_rdy=1 -> bfu_out completes at once. stream msg stays stable; cmd_in_t_rdy stays 0 until the stream transfer; then return to IDLE.
- Offset truncation: bt0=48, A=all-ones -> data[511:384] all ones. The upper 64 bits of A are dropped and no wrap to byte 0 occurs.
- Reset during RSP: assert i_rst while rdrsp is pending -> no stream/bfu_out val is ever emitted. After release, a new command is processed normally.
